// File: rtl/vga_color_stage_pkg.sv
// Shared definitions for the VGA colour stage: default palette, scanline
// dimming level codes and the palette-write FSM state type.
package vga_color_stage_pkg;

    localparam int unsigned DEF_CH_BITS = 6;

    localparam logic [1:0] SCAN_LVL_100 = 2'd0;
    localparam logic [1:0] SCAN_LVL_75  = 2'd1;
    localparam logic [1:0] SCAN_LVL_50  = 2'd2;
    localparam logic [1:0] SCAN_LVL_25  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } wr_state_e;

    // {R,G,B}, 6 bits per channel
    localparam logic [3*DEF_CH_BITS-1:0] DEFAULT_PALETTE [16] = '{
        {6'h00, 6'h00, 6'h00},
        {6'h3F, 6'h3F, 6'h3F},
        {6'h2A, 6'h00, 6'h00},
        {6'h15, 6'h3F, 6'h3F},
        {6'h2A, 6'h00, 6'h2A},
        {6'h00, 6'h2A, 6'h00},
        {6'h00, 6'h00, 6'h2A},
        {6'h3F, 6'h3F, 6'h15},
        {6'h3F, 6'h20, 6'h04},
        {6'h20, 6'h10, 6'h00},
        {6'h3F, 6'h15, 6'h15},
        {6'h15, 6'h15, 6'h15},
        {6'h20, 6'h20, 6'h20},
        {6'h15, 6'h3F, 6'h15},
        {6'h15, 6'h15, 6'h3F},
        {6'h2A, 6'h2A, 6'h2A}
    };

endpackage

// File: rtl/vga_color_stage_palette_ram.sv
// Palette register file: one synchronous write port, one registered read
// port, defaults loaded while reset is held.
module color_palette_ram
    import vga_color_stage_pkg::*;
#(
    parameter int unsigned RGB_BITS   = 6,
    parameter int unsigned NUM_COLORS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [3:0]            i_wr_addr,
    input  logic [3*RGB_BITS-1:0] i_wr_data,
    input  logic [3:0]            i_rd_addr,
    output logic [3*RGB_BITS-1:0] o_rd_data
);

    localparam int unsigned W   = 3 * RGB_BITS;
    localparam int unsigned AW  = $clog2(NUM_COLORS);
    localparam int unsigned SHL = (RGB_BITS > DEF_CH_BITS) ? RGB_BITS - DEF_CH_BITS : 0;
    localparam int unsigned SHR = (RGB_BITS < DEF_CH_BITS) ? DEF_CH_BITS - RGB_BITS : 0;

    logic [W-1:0] r_mem [NUM_COLORS];
    logic [W-1:0] r_rd_data;

    // Rescale the 6-bit default channels to RGB_BITS by left-justifying.
    function automatic logic [W-1:0] default_entry(input int unsigned idx);
        logic [3*DEF_CH_BITS-1:0] d;
        logic [W-1:0]             e;
        d = DEFAULT_PALETTE[4'(idx)];
        e = '0;
        e[3*RGB_BITS-1 -: RGB_BITS] = RGB_BITS'((32'(d[17:12]) << SHL) >> SHR);
        e[2*RGB_BITS-1 -: RGB_BITS] = RGB_BITS'((32'(d[11:6])  << SHL) >> SHR);
        e[RGB_BITS-1   -: RGB_BITS] = RGB_BITS'((32'(d[5:0])   << SHL) >> SHR);
        return e;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_COLORS; i++) begin
                r_mem[AW'(i)] <= default_entry(i);
            end
            r_rd_data <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vga_color_stage.sv
// Two-stage colour pipeline: palette lookup, then scanline dimming and
// blanking, with a deferrable one-slot palette write port.
module vga_color_stage
    import vga_color_stage_pkg::*;
#(
    parameter int unsigned RGB_BITS   = 6,
    parameter int unsigned NUM_COLORS = 16
) (
    input  logic                  clk_dot4x,
    input  logic                  rst_n,
    input  logic [3:0]            pixel_color4,
    input  logic                  active_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  half_bright_in,
    input  logic                  scanline_en,
    input  logic [1:0]            scan_level,
    input  logic                  defer_en,
    input  logic                  wr_valid,
    input  logic [3:0]            wr_index,
    input  logic [3*RGB_BITS-1:0] wr_rgb,
    output logic                  wr_ready,
    output logic                  wr_done,
    output logic [RGB_BITS-1:0]   red,
    output logic [RGB_BITS-1:0]   green,
    output logic [RGB_BITS-1:0]   blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  active
);

    localparam int unsigned W = 3 * RGB_BITS;

    wr_state_e         r_state;
    wr_state_e         w_state_next;
    logic              r_ready_en;
    logic [3:0]        r_slot_idx;
    logic [W-1:0]      r_slot_rgb;
    logic              w_ready;
    logic              w_done;
    logic              w_accept;

    logic [W-1:0]      w_pal_rgb;
    logic              r_active1, r_hs1, r_vs1, r_half1, r_scen1;
    logic [1:0]        r_lvl1;
    logic [1:0]        w_dim_lvl;
    logic [RGB_BITS-1:0] r_red, r_green, r_blue;
    logic              r_hs2, r_vs2, r_active2;

    function automatic logic [RGB_BITS-1:0] dim(input logic [RGB_BITS-1:0] c,
                                                input logic [1:0] lvl);
        case (lvl)
            SCAN_LVL_100: return c;
            SCAN_LVL_75:  return c - (c >> 2);
            SCAN_LVL_50:  return c >> 1;
            default:      return c >> 2;
        endcase
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = r_ready_en;
                if (wr_valid && r_ready_en) w_state_next = PEND;
            end
            PEND: begin
                if (!defer_en || !active_in) w_state_next = COMMIT;
            end
            COMMIT: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = wr_valid && w_ready;

    // r_ready_en keeps wr_ready low until the first clock after reset release.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ready_en <= 1'b0;
            r_slot_idx <= '0;
            r_slot_rgb <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_slot_idx <= wr_index;
                r_slot_rgb <= wr_rgb;
            end
        end
    end

    assign wr_ready = w_ready;
    assign wr_done  = w_done;

    color_palette_ram #(
        .RGB_BITS   (RGB_BITS),
        .NUM_COLORS (NUM_COLORS)
    ) u_palette (
        .i_clk     (clk_dot4x),
        .i_rst_n   (rst_n),
        .i_we      (w_done),
        .i_wr_addr (r_slot_idx),
        .i_wr_data (r_slot_rgb),
        .i_rd_addr (pixel_color4),
        .o_rd_data (w_pal_rgb)
    );

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            r_active1 <= 1'b0;
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
            r_half1   <= 1'b0;
            r_scen1   <= 1'b0;
            r_lvl1    <= '0;
        end else begin
            r_active1 <= active_in;
            r_hs1     <= hsync_in;
            r_vs1     <= vsync_in;
            r_half1   <= half_bright_in;
            r_scen1   <= scanline_en;
            r_lvl1    <= scan_level;
        end
    end

    assign w_dim_lvl = (r_scen1 && r_half1) ? r_lvl1 : SCAN_LVL_100;

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_hs2     <= 1'b0;
            r_vs2     <= 1'b0;
            r_active2 <= 1'b0;
        end else begin
            r_red     <= r_active1 ? dim(w_pal_rgb[W-1 -: RGB_BITS], w_dim_lvl) : '0;
            r_green   <= r_active1 ? dim(w_pal_rgb[2*RGB_BITS-1 -: RGB_BITS], w_dim_lvl) : '0;
            r_blue    <= r_active1 ? dim(w_pal_rgb[RGB_BITS-1 -: RGB_BITS], w_dim_lvl) : '0;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_active2 <= r_active1;
        end
    end

    assign red    = r_red;
    assign green  = r_green;
    assign blue   = r_blue;
    assign hsync  = r_hs2;
    assign vsync  = r_vs2;
    assign active = r_active2;

endmodule

// File: doc/vga_color_stage.md
VGA_COLOR_STAGE -- requirements
Module: vga_color_stage

Interface
REQ-001 Parameter RGB_BITS, default 6, bits per colour channel.
REQ-002 Parameter NUM_COLORS, default 16, palette entries, indexed by a 4-bit colour index.
REQ-003 clk_dot4x  in  1  4x dot clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 pixel_color4  in  4  colour index from the line-doubler stage.
REQ-006 active_in  in  1  high during active pixels, aligned with pixel_color4.
REQ-007 hsync_in / vsync_in  in  1 each  syncs, polarity already applied upstream; passed through, never inverted.
REQ-008 half_bright_in  in  1  high on alternate (doubled) output lines.
REQ-009 scanline_en  in  1  enables scanline dimming.
REQ-010 scan_level  in  2  dimming level: 0=100%, 1=75%, 2=50%, 3=25%.
REQ-011 defer_en  in  1  high: palette writes commit only during blanking.
REQ-012 wr_valid  in  1  palette write request.
REQ-013 wr_index  in  4  palette entry to write.
REQ-014 wr_rgb  in  3*RGB_BITS  {R,G,B}, R in MSBs.
REQ-015 wr_ready  out  1  high when a write can be accepted.
REQ-016 wr_done  out  1  one-cycle pulse on the cycle the palette entry is updated.
REQ-017 red / green / blue  out  RGB_BITS each  registered output colour.
REQ-018 hsync / vsync / active  out  1 each  registered syncs and active, aligned with the RGB outputs.

Function
REQ-019 Pipeline latency is exactly 2 clk_dot4x cycles from the inputs to all outputs (RGB, hsync, vsync, active); every cycle advances, and there is no stall.
REQ-020 Stage 1 registers palette[pixel_color4], active_in, hsync_in, vsync_in, half_bright_in, scanline_en and scan_level.
REQ-021 Stage 2 applies dimming per channel c, but only when both the stage-1 scanline_en and half_bright are high: level 0 gives c; level 1 gives c-(c>>2); level 2 gives c>>1; level 3 gives c>>2. Results truncate and never underflow.
REQ-022 When the stage-1 active is low, stage 2 drives red, green and blue to 0.
REQ-023 The write handshake has one pending slot; a write is accepted in a cycle where wr_valid and wr_ready are both high, and index and rgb are captured into the slot.
REQ-024 The write FSM has three states:
- IDLE (wr_ready=1): on accept, go to PEND.
- PEND (wr_ready=0): if defer_en=0, or active_in=0 this cycle, go to COMMIT; otherwise stay in PEND.
- COMMIT (wr_ready=0): write the palette entry, pulse wr_done, then return to IDLE.
REQ-025 wr_ready rises the cycle after COMMIT, so back-to-back writes are separated by at least 3 cycles.
REQ-026 If a commit and a read of the same index fall in the same cycle, the read returns the old value; the new value is visible from the next cycle.
REQ-027 A write held in PEND while active_in stays high waits indefinitely. The FSM has no timeout.
REQ-028 If defer_en changes while the FSM is in PEND, the new value is evaluated the next cycle.
REQ-029 wr_index and wr_rgb are ignored outside the accept cycle.

Reset
REQ-030 While rst_n is low: red, green, blue, hsync, vsync, active and wr_done are 0; wr_ready is 0; the FSM is in IDLE; all pipeline registers are 0.
REQ-031 While rst_n is low, the palette loads DEFAULT_PALETTE.
REQ-032 wr_ready goes to 1 on the first clock after rst_n deasserts.
REQ-033 Reset in PEND or COMMIT discards the pending write; the palette holds default values.

Structure
REQ-034 A shared package holds:
- DEFAULT_PALETTE, 16 entries × 18 bits;
- the scan_level encoding constants;
- the FSM state typedef (IDLE, PEND, COMMIT).
REQ-035 One sub-module, color_palette_ram, holds the NUM_COLORS×(3*RGB_BITS) register file with one sync write port, one registered read port and async-reset load of defaults. All other logic lives in vga_color_stage.

Verification
REQ-036 Reset release, then pixel_color4=1 with active_in=1 -> two cycles later the RGB output equals DEFAULT_PALETTE[1] (white 3F,3F,3F); with active_in=0 the output is 0,0,0.
REQ-037 Toggle hsync_in and vsync_in in a known pattern -> hsync/vsync reproduce the pattern exactly 2 cycles later, with no inversion.
REQ-038 scanline_en=1, half_bright_in=1, colour 3F,20,04, scan_level 0/1/2/3 -> outputs 3F,20,04 / 30,18,03 / 1F,10,02 / 0F,08,01; with half_bright_in=0 the output is always 3F,20,04.
REQ-039 defer_en=1, active_in=1, write idx 1 = 00,00,3F -> wr_ready=0, no wr_done while active stays high; drop active_in -> wr_done the cycle after PEND sees active low; the next display of idx 1 is 00,00,3F.
REQ-040 defer_en=0, two back-to-back writes with wr_valid held -> accepts exactly 3 cycles apart, two wr_done pulses; a same-cycle read during COMMIT returns the old value.
REQ-041 Assert rst_n low while the FSM is in PEND -> no wr_done; the palette is all defaults; wr_ready=1 one cycle after release.
